vec_wb_collect: RTL

Writeback collector directly downstream of the vec_alu lanes. It gathers the per-cycle result slices each active lane produces (lane vd plus the lane's reg_index bit offset) into one VLEN-wide destination image. It tracks byte coverage and, once the whole register is written, presents it on a valid/ready port to the vector register file write side. It replaces the ad-hoc slice merging currently done around the ALU lanes.

---
 rtl/vec_wb_collect_if.sv | 10 +
 rtl/vec_wb_collect.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/vec_wb_collect_if.sv
// Writeback handshake between the collector and the vector register file write side.
interface vec_wb_collect_if #(parameter int VLEN = 128);
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_vd_idx;
  logic [VLEN-1:0] wb_data;

  modport master (output wb_valid, wb_vd_idx, wb_data, input wb_ready);
  modport slave  (input wb_valid, wb_vd_idx, wb_data, output wb_ready);
endinterface

// File: rtl/vec_wb_collect.sv
// Gathers per-lane ALU result slices into one destination register image and
// hands it to the register file once every byte has been written.
module vec_wb_lane #(
  parameter  int VLEN = 128,
  localparam int NB   = VLEN / 8
) (
  input  logic [3:0]    wlog,
  input  logic [9:0]    idx,
  output logic          ok,
  output logic [NB-1:0] bmask
);
  logic [10:0] w, lo, hi;

  assign w  = 11'd1 << wlog;
  assign lo = {1'b0, idx};
  assign hi = lo + w;
  assign ok = ((lo & (w - 11'd1)) == 11'd0) && (hi <= 11'(VLEN));

  always_comb begin
    bmask = '0;
    for (int b = 0; b < NB; b++)
      bmask[b] = (11'(b * 8) >= lo) && (11'(b * 8) < hi);
  end
endmodule

module vec_wb_collect #(
  parameter int VLEN         = 128,
  parameter int LANE_WIDTH   = 5,
  parameter int NB_LANES_MAX = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [2:0]                   vsew,
  input  logic [1:0]                   nb_lanes,
  input  logic [4:0]                   vd_idx,
  input  logic [NB_LANES_MAX*VLEN-1:0] lane_vd,
  input  logic [NB_LANES_MAX*10-1:0]   lane_idx,
  input  logic [NB_LANES_MAX-1:0]      lane_valid,
  vec_wb_collect_if.master             wb,
  output logic                         busy,
  output logic                         err
);
  localparam int NB = VLEN / 8;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;
  typedef struct packed {
    logic [2:0] vsew;
    logic [1:0] nbl;
    logic [4:0] vd;
  } op_t;

  state_t          state;
  op_t             op_q;
  logic [VLEN-1:0] acc, acc_nxt;
  logic [NB-1:0]   mask, mask_nxt;
  logic            err_nxt;
  logic [3:0]      esz, wlog;

  logic [NB_LANES_MAX-1:0]         act, ok;
  logic [NB_LANES_MAX-1:0][NB-1:0] bmask;

  // Slice width is the element width, capped by the lane datapath width.
  assign esz  = {1'b0, op_q.vsew} + 4'd3;
  assign wlog = (esz > 4'(LANE_WIDTH)) ? 4'(LANE_WIDTH) : esz;

  for (genvar g = 0; g < NB_LANES_MAX; g++) begin : g_lane
    localparam int unsigned LI = g;
    assign act[g] = (state == COLLECT) && lane_valid[g] && ((LI >> op_q.nbl) == 32'd0);
    vec_wb_lane #(.VLEN(VLEN)) u_lane (
      .wlog  (wlog),
      .idx   (lane_idx[g*10 +: 10]),
      .ok    (ok[g]),
      .bmask (bmask[g])
    );
  end

  // Lanes are merged in index order so a lower lane claims overlapping bytes first.
  always_comb begin
    acc_nxt  = acc;
    mask_nxt = mask;
    err_nxt  = 1'b0;
    for (int i = 0; i < NB_LANES_MAX; i++) begin
      if (act[i]) begin
        if (ok[i] && ((bmask[i] & mask_nxt) == '0)) begin
          mask_nxt = mask_nxt | bmask[i];
          for (int b = 0; b < NB; b++)
            if (bmask[i][b]) acc_nxt[b*8 +: 8] = lane_vd[i*VLEN + b*8 +: 8];
        end else begin
          err_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      op_q         <= '0;
      acc          <= '0;
      mask         <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
      wb.wb_valid  <= 1'b0;
      wb.wb_vd_idx <= '0;
      wb.wb_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= '{vsew: vsew, nbl: nb_lanes, vd: vd_idx};
            acc   <= '0;
            mask  <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          acc  <= acc_nxt;
          mask <= mask_nxt;
          if (err_nxt) err <= 1'b1;
          if (&mask_nxt) begin
            state        <= WRITE;
            wb.wb_valid  <= 1'b1;
            wb.wb_data   <= acc_nxt;
            wb.wb_vd_idx <= op_q.vd;
          end
        end
        WRITE: begin
          if (wb.wb_ready) begin
            state       <= IDLE;
            wb.wb_valid <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
